// File: rtl/ctrl_redirect_stage_pkg.sv
// Shared constants and types for the control redirect stage.
package ctrl_redirect_stage_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned AL_ID_W_DEF = 7;
  localparam int unsigned FLAG_W_DEF  = 8;

  // Execution-flag bit positions
  localparam int unsigned FLAG_MISPRED = 0;
  localparam int unsigned FLAG_EXEC    = 2;
  localparam int unsigned FLAG_LINK    = 4;
  localparam int unsigned FLAG_COND    = 5;
  localparam int unsigned FLAG_CTRL    = 7;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_WAIT_FLUSH = 2'd2
  } redir_state_e;

endpackage

// File: rtl/al_age_compare.sv
// Combinational check: is a_id strictly older than b_id relative to the active-list head.
module al_age_compare #(
  parameter int unsigned AL_ID_W = 7
) (
  input  logic [AL_ID_W-1:0] a_id,
  input  logic [AL_ID_W-1:0] b_id,
  input  logic [AL_ID_W-1:0] head,
  output logic               older_c
);

  logic [AL_ID_W-1:0] a_age;
  logic [AL_ID_W-1:0] b_age;

  // Modulo subtraction keeps the compare correct across ID wrap; equal age is not older
  always_comb begin
    a_age   = a_id - head;
    b_age   = b_id - head;
    older_c = (a_age < b_age);
  end

endmodule

// File: rtl/ctrl_redirect_stage.sv
// Registered stage after the control ALU: writeback, predictor update and a single
// oldest-mispredict redirect request held until the active list flushes.
module ctrl_redirect_stage
  import ctrl_redirect_stage_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned AL_ID_W = AL_ID_W_DEF,
  parameter int unsigned FLAG_W  = FLAG_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [AL_ID_W-1:0] alId_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    result_i,
  input  logic [PC_W-1:0]    nextPC_i,
  input  logic               direction_i,
  input  logic [FLAG_W-1:0]  flags_i,
  input  logic [AL_ID_W-1:0] alHead_i,
  input  logic               flush_i,
  output logic               wbValid_o,
  output logic [AL_ID_W-1:0] wbAlId_o,
  output logic [PC_W-1:0]    wbResult_o,
  output logic [FLAG_W-1:0]  wbFlags_o,
  output logic               bpValid_o,
  output logic [PC_W-1:0]    bpPC_o,
  output logic               bpDir_o,
  output logic [PC_W-1:0]    bpTarget_o,
  output logic               redirValid_o,
  input  logic               redirReady_i,
  output logic [PC_W-1:0]    redirPC_o,
  output logic [AL_ID_W-1:0] redirAlId_o
);

  redir_state_e       state_q;
  redir_state_e       state_d;
  logic [PC_W-1:0]    redir_pc_d;
  logic [AL_ID_W-1:0] redir_id_d;
  logic               mispred_c;
  logic               exec_c;
  logic               older_c;
  logic               handshake_c;

  al_age_compare #(
    .AL_ID_W (AL_ID_W)
  ) u_age (
    .a_id    (alId_i),
    .b_id    (redirAlId_o),
    .head    (alHead_i),
    .older_c (older_c)
  );

  // Writeback and predictor-update register, loaded every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbValid_o  <= 1'b0;
      wbAlId_o   <= '0;
      wbResult_o <= '0;
      wbFlags_o  <= '0;
      bpValid_o  <= 1'b0;
      bpPC_o     <= '0;
      bpDir_o    <= 1'b0;
      bpTarget_o <= '0;
    end else begin
      wbValid_o  <= exec_c & ~flush_i;
      wbAlId_o   <= alId_i;
      wbResult_o <= result_i;
      wbFlags_o  <= flags_i;
      bpValid_o  <= exec_c & flags_i[FLAG_COND] & ~flush_i;
      bpPC_o     <= pc_i;
      bpDir_o    <= direction_i;
      bpTarget_o <= nextPC_i;
    end
  end

  // Redirect FSM state and held request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      redirValid_o <= 1'b0;
      redirPC_o    <= '0;
      redirAlId_o  <= '0;
    end else begin
      state_q      <= state_d;
      redirValid_o <= (state_d == ST_REQ);
      redirPC_o    <= redir_pc_d;
      redirAlId_o  <= redir_id_d;
    end
  end

  // Next-state: handshake beats replacement, flush beats everything
  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redirPC_o;
    redir_id_d  = redirAlId_o;
    exec_c      = valid_i & flags_i[FLAG_EXEC];
    mispred_c   = valid_i & flags_i[FLAG_MISPRED];
    handshake_c = redirValid_o & redirReady_i;

    case (state_q)
      ST_IDLE: begin
        if (mispred_c) begin
          redir_pc_d = nextPC_i;
          redir_id_d = alId_i;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (handshake_c) begin
          state_d = ST_WAIT_FLUSH;
        end else if (mispred_c && older_c) begin
          redir_pc_d = nextPC_i;
          redir_id_d = alId_i;
        end
      end
      ST_WAIT_FLUSH: begin
        state_d = ST_WAIT_FLUSH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d    = ST_IDLE;
      redir_pc_d = redirPC_o;
      redir_id_d = redirAlId_o;
    end
  end

endmodule

// File: doc/ctrl_redirect_stage.md
# ctrl_redirect_stage

Registered stage directly downstream of the control ALU. It captures the branch/jump resolution each cycle and forwards it as a writeback packet and a branch-predictor update. It also turns mispredicts into a single redirect request to fetch. While a redirect is outstanding it arbitrates by active-list age, so that only the oldest mispredict redirects the front end. It then masks further redirects until the active list issues a flush.

## Interface
Parameters:
- `PC_W`, 32, width of PC, result and target fields.
- `AL_ID_W`, 7, width of the active-list ID; age arithmetic is modulo 2^AL_ID_W.
- `FLAG_W`, 8, width of the execution-flag vector.

Ports:
- `clk`  in  1  Sole clock; all state on rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `valid_i`  in  1  Control-ALU result valid this cycle.
- `alId_i`  in  AL_ID_W  Active-list ID of the resolving instruction.
- `pc_i`  in  PC_W  PC of the resolving instruction.
- `result_i`  in  PC_W  Link value (pc+8) from the ALU.
- `nextPC_i`  in  PC_W  Resolved next PC.
- `direction_i`  in  1  Resolved taken/not-taken.
- `flags_i`  in  FLAG_W  Execution flags.
- `alHead_i`  in  AL_ID_W  Current active-list head ID (oldest in flight).
- `flush_i`  in  1  Active-list recovery flush; squashes all younger work.
- `wbValid_o`  out  1  Writeback packet valid.
- `wbAlId_o`  out  AL_ID_W  Writeback active-list ID.
- `wbResult_o`  out  PC_W  Writeback link value.
- `wbFlags_o`  out  FLAG_W  Writeback flags.
- `bpValid_o`  out  1  Predictor update valid.
- `bpPC_o`  out  PC_W  Predictor update PC.
- `bpDir_o`  out  1  Predictor update direction.
- `bpTarget_o`  out  PC_W  Predictor update target.
- `redirValid_o`  out  1  Redirect request to fetch.
- `redirReady_i`  in  1  Fetch accepts the redirect.
- `redirPC_o`  out  PC_W  Redirect target.
- `redirAlId_o`  out  AL_ID_W  ID of the mispredicting instruction.

## Operation
Flag bits:
- b0 mispredict, b2 executed, b4 writes-link, b5 conditional, b7 control.

Writeback and predictor update:
- The writeback/BP register loads every cycle from the inputs.
- `wbValid_o` is `valid_i & flags_i[2]`, registered.
- `bpValid_o` is `valid_i & flags_i[2] & flags_i[5]`, registered.
- `bpTarget_o` is `nextPC_i`.

Age:
- age(x) = (x − `alHead_i`) mod 2^AL_ID_W, evaluated on the cycle of capture.
- A smaller age is older.

Redirect FSM, states IDLE, REQ and WAIT_FLUSH:
- IDLE: a valid mispredict (`valid_i & flags_i[0]`) loads `redirPC` ← `nextPC_i` and `redirAlId` ← `alId_i`, then moves to REQ.
- REQ:
  - `redirValid_o` = 1.
  - An incoming valid mispredict strictly older than the held ID replaces the PC and ID and stays in REQ. The replacement is visible next cycle.
  - A younger or equal-age mispredict is dropped.
  - `redirValid_o & redirReady_i` moves to WAIT_FLUSH.
  - If the replacement and the handshake occur in the same cycle, the handshake wins: the held PC is the one accepted and the incoming mispredict is dropped.
- WAIT_FLUSH:
  - All incoming mispredicts are ignored; they are younger and will be squashed.
  - Writeback and BP outputs continue normally.
  - `flush_i` moves to IDLE.

Flush:
- `flush_i` in any state clears the FSM to IDLE and zeroes `wbValid_o`/`bpValid_o` on the next edge.
- A mispredict arriving in the same cycle as `flush_i` is discarded.

## Timing
- Latency from input to wb/bp outputs: 1 cycle.
- Latency from a first mispredict in IDLE to `redirValid_o`: 1 cycle.
- `redirPC_o`/`redirAlId_o` are stable while `redirValid_o=1 & redirReady_i=0`, except for an older-replacement update.
- Fetch must tolerate the target changing before acceptance.
- Reset (asynchronous, active-low): all outputs 0, FSM in IDLE.
- Reset mid-REQ drops the request immediately, with no handshake.
- Wrap-around: the age compare is correct across ID wrap; the equal-age case is treated as not older.

## Structure
- Shared package holds:
  - flag-bit index constants (`FLAG_MISPRED`, `FLAG_EXEC`, `FLAG_LINK`, `FLAG_COND`, `FLAG_CTRL`);
  - the FSM state enum;
  - the `PC_W`/`AL_ID_W` defaults.
- One sub-module, `al_age_compare`: combinational older-than check on two IDs against the head, used by the REQ replacement logic.

## Test plan
- BEQ resolved taken, with `flags_i=8'hA5`, `alId_i=5` and `nextPC_i=0x1040`: next cycle `wbValid_o=1` and `bpValid_o=1`, `redirValid_o=1`, `redirPC_o=0x1040`, `redirAlId_o=5`.
- Hold `redirReady_i=0`, head=0. A mispredict with id 3 replaces id 5. Then a mispredict with id 9 is ignored. `redirReady_i=1` then shows id 3 accepted and the FSM in WAIT_FLUSH.
- Wrap: head=120 and held id=2. Incoming id=125 is older and replaces; incoming id=4 does not.
- In WAIT_FLUSH a new mispredict produces no `redirValid_o`. Assert `flush_i`, then the next mispredict redirects in 1 cycle.
- Handshake and older replacement in the same cycle: the original PC is accepted, the FSM enters WAIT_FLUSH, and there is no second request.
- Assert `reset` low while in REQ: all outputs 0 immediately. On release, the FSM is in IDLE and the first mispredict redirects normally.
